// File: rtl/instruction_memory_unit.sv
// Loadable instruction memory for the miniMIPS fetch stage: one registered fetch per cycle
// in RUN, run-time program loading through a valid/ready port in LOAD.
module instruction_memory_unit #(
   parameter int                     INSTR_WIDTH = 16,
   parameter int                     ADDR_WIDTH  = 6,
   parameter int                     DEPTH       = 64,
   parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fetch_req,
   input  logic [ADDR_WIDTH-1:0]  read_adress,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instr_valid,
   output logic                   instr_fault,
   input  logic                   load_start,
   input  logic [ADDR_WIDTH-1:0]  load_base,
   input  logic                   load_valid,
   input  logic [INSTR_WIDTH-1:0] load_data,
   output logic                   load_ready,
   input  logic                   load_last,
   output logic                   load_busy,
   output logic                   load_overflow
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {ST_RUN, ST_LOAD} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic                   load_overflow_q, load_overflow_d;
   logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
   logic                   instr_valid_q, instr_valid_d;
   logic                   instr_fault_q, instr_fault_d;

   logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
   logic                   mem_we;
   logic                   load_accept;
   logic                   fetch_accept;

   // Load handshake: a beat transfers when load_valid & load_ready on a rising edge.
   // load_ready is high in LOAD without overflow; a beat coinciding with load_start or
   // reset is dropped because the session is being restarted or abandoned.
   assign load_ready    = (state_q == ST_LOAD) && !load_overflow_q;
   assign load_busy     = (state_q == ST_LOAD);
   assign load_overflow = load_overflow_q;
   assign instruction   = instruction_q;
   assign instr_valid   = instr_valid_q;
   assign instr_fault   = instr_fault_q;

   assign load_accept  = load_ready && load_valid && !load_start && !reset;
   assign fetch_accept = (state_q == ST_RUN) && fetch_req && !load_start;
   assign mem_we       = load_accept;

   always_comb begin
      state_d         = state_q;
      wr_ptr_d        = wr_ptr_q;
      load_overflow_d = load_overflow_q;
      instruction_d   = instruction_q;
      instr_valid_d   = 1'b0;
      instr_fault_d   = 1'b0;

      if (load_start) begin
         state_d         = ST_LOAD;
         wr_ptr_d        = load_base;
         load_overflow_d = ({1'b0, load_base} >= DEPTH_EXT);
      end else if (load_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         // Writing the top word ends the session whether or not the source was done.
         if (load_last || (wr_ptr_q == LAST_ADDR)) begin
            state_d = ST_RUN;
         end
         if ((wr_ptr_q == LAST_ADDR) && !load_last) begin
            load_overflow_d = 1'b1;
         end
      end

      if (fetch_accept) begin
         instr_valid_d = 1'b1;
         if ({1'b0, read_adress} < DEPTH_EXT) begin
            instruction_d = mem_q[read_adress];
         end else begin
            instruction_d = NOP_WORD;
            instr_fault_d = 1'b1;
         end
      end else if (fetch_req) begin
         instruction_d = NOP_WORD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_RUN;
         wr_ptr_q        <= '0;
         load_overflow_q <= 1'b0;
         instruction_q   <= NOP_WORD;
         instr_valid_q   <= 1'b0;
         instr_fault_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         wr_ptr_q        <= wr_ptr_d;
         load_overflow_q <= load_overflow_d;
         instruction_q   <= instruction_d;
         instr_valid_q   <= instr_valid_d;
         instr_fault_q   <= instr_fault_d;
      end
   end

   // Program store survives reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= load_data;
      end
   end

endmodule

// File: doc/instruction_memory_unit.md
# instruction_memory_unit

Parametrised, loadable instruction memory for the miniMIPS fetch stage. It replaces the fixed 16-bit × 64-entry ROM-style store with a configurable-width, configurable-depth array. Its contents are written at run time through a valid/ready load port, so programs no longer need to be preloaded by the testbench. Fetches return one instruction per cycle with a fixed one-cycle latency, a valid flag, and an out-of-range fault flag.

## Interface
Parameters:
- INSTR_WIDTH, 16, bits per instruction word
- ADDR_WIDTH, 6, width of fetch and load addresses
- DEPTH, 64, number of implemented words; must satisfy DEPTH ≤ 2^ADDR_WIDTH
- NOP_WORD, 16'h0000, value driven on `instruction` for faulted or blocked fetches

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- fetch_req  input  1  request a fetch this cycle
- read_adress  input  ADDR_WIDTH  fetch address, sampled when fetch_req=1
- instruction  output  INSTR_WIDTH  fetched word (registered)
- instr_valid  output  1  `instruction` holds the result of the previous cycle's accepted fetch
- instr_fault  output  1  the previous fetch targeted address ≥ DEPTH
- load_start  input  1  enter LOAD mode with write pointer set to load_base
- load_base  input  ADDR_WIDTH  first address written in a load session
- load_valid  input  1  load_data is valid
- load_data  input  INSTR_WIDTH  word to write
- load_ready  output  1  unit accepts load_data this cycle
- load_last  input  1  marks the final word of the session (qualified by load_valid & load_ready)
- load_busy  output  1  unit is in LOAD mode
- load_overflow  output  1  sticky flag: the session ran past DEPTH-1

## Operation
States:
- RUN: fetches are served.
- LOAD: words are written at wr_ptr.

Transitions:
- RUN→LOAD on load_start=1.
  - wr_ptr ← load_base.
  - load_overflow ← 1 if load_base ≥ DEPTH, else 0.
- LOAD→RUN on an accepted beat (load_valid & load_ready) with load_last=1.
- LOAD→RUN also when wr_ptr = DEPTH-1 is written: auto-terminate, load_overflow ← 1 if load_last=0 on that beat.
- load_start asserted while already in LOAD restarts the session at the new load_base; any beat presented that same cycle is discarded.

Load rules:
- load_ready = (state==LOAD) & ~load_overflow.
- A beat is accepted when load_valid & load_ready. On acceptance: mem[wr_ptr] ← load_data, then wr_ptr ← wr_ptr+1.
- A session started with load_base ≥ DEPTH never accepts data. It stays in LOAD until reset or a new load_start.

Fetch rules:
- A fetch is accepted only when state==RUN and fetch_req=1. The response appears the next cycle:
  - instr_valid=1.
  - If read_adress < DEPTH: instruction = mem[read_adress], instr_fault=0.
  - If read_adress ≥ DEPTH: instruction = NOP_WORD, instr_fault=1.
- fetch_req=1 in LOAD or in the cycle of load_start: the fetch is blocked.
  - Next cycle: instr_valid=0, instr_fault=0, instruction=NOP_WORD.
- fetch_req=0: next cycle instr_valid=0 and instr_fault=0. `instruction` holds its previous value.

Reset:
- Memory contents are NOT cleared by reset.
- Reset forces state=RUN and wr_ptr=0.
- Reset mid-load abandons the session. Words already written remain.

## Timing
- Reset values: instruction=NOP_WORD, instr_valid=0, instr_fault=0, load_ready=0, load_busy=0, load_overflow=0.
- Fetch latency: exactly 1 cycle. Throughput: 1 fetch/cycle in RUN.
- Read-during-write: loads and fetches never overlap, so no same-cycle read-during-write case exists.
- The first fetch in the cycle after LOAD→RUN returns the newly written data.
- load_ready rises the cycle after load_start. Load throughput: 1 word/cycle.
- load_busy = (state==LOAD) and is registered.
- The last-beat cycle writes mem. load_busy falls on the next edge.
- load_overflow is set on the edge of the overflow condition. It clears only on the next load_start or on reset.

## Test plan
- Reset, then fetch 0: reset holds outputs at NOP_WORD/0/0. Fetch of address 0 returns instr_valid=1 with the pre-existing contents one cycle later. A second reset leaves memory intact.
- Load 4 words 16'h1111, 16'h2222, 16'h3333, 16'h4444 from load_base=5, last on the 4th beat, with load_valid gaps inserted.
  - Required: load_busy falls one cycle after the 4th beat.
  - Back-to-back fetches of 5..8 return those words on consecutive cycles, each with instr_valid=1.
- DEPTH=48, ADDR_WIDTH=6, fetch address 50: next cycle instruction=NOP_WORD, instr_fault=1, instr_valid=1. Fetch 47 returns mem[47] with instr_fault=0.
- Load from load_base=62 (DEPTH=64) with 3 beats, load_last only on the 3rd.
  - Beats 1–2 write mem[62] and mem[63].
  - Auto-terminate after mem[63]; load_overflow=1; the 3rd beat is never accepted (load_ready=0).
- fetch_req=1 during LOAD: instr_valid=0 and instruction=NOP_WORD the next cycle. Memory is unchanged by the fetch address.
- Reset asserted after 2 of 5 load beats: state=RUN, load_busy=0, load_ready=0 next cycle. The two written words read back correctly. The remaining addresses hold their old values.
